// File: rtl/chg_log.sv
// chg_log: change logger that timestamps in_data value changes into a show-ahead FIFO
// Ports: clk/rst_n (async active-low reset); in_valid/in_data sampled stream;
//   rd_en pops head; clr_ovf clears overflow; rd_valid/rd_data/rd_time head view
//   (zero when empty); count entries held; overflow sticky drop flag.
// Option: define CHG_LOG_FIRST_SAMPLE_EN to also log the first sample after reset.
module chg_log #(
  parameter int DW    = 4,
  parameter int TW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic [TW-1:0]              rd_time,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef CHG_LOG_FIRST_SAMPLE_EN
  localparam logic FIRST = 1'b1;
`else
  localparam logic FIRST = 1'b0;
`endif
  logic [TW-1:0]    r_ts;
  logic [DW-1:0]    r_last;
  logic             r_have;
  logic [TW+DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             w_change, w_pop, w_full, w_push, w_drop;
  // before the reference is seeded, only the optional first-sample logging can push
  assign w_change = in_valid && (r_have ? (in_data != r_last) : FIRST);
  assign w_pop    = rd_en && (r_cnt != '0);
  assign w_full   = r_cnt == CW'(DEPTH);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push   = w_change && (!w_full || w_pop);
  assign w_drop   = w_change && w_full && !w_pop;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {r_ts, in_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ts   <= '0;
      r_last <= '0;
      r_have <= 1'b0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_ts <= r_ts + TW'(1);
      if (in_valid) begin
        r_last <= in_data;
        r_have <= 1'b1;
      end
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ovf <= w_drop | (r_ovf & ~clr_ovf);
    end
  assign rd_valid           = r_cnt != '0;
  assign {rd_time, rd_data} = rd_valid ? r_mem[r_rp] : '0;
  assign count              = r_cnt;
  assign overflow           = r_ovf;
endmodule

// File: tb/tb_chg_log.sv
// tb_chg_log: scoreboard bench for chg_log (directed vectors, popped entries checked by a monitor)
module tb_chg_log;
  localparam int DW = 4, TW = 8, DEPTH = 8;
`ifdef CHG_LOG_FIRST_SAMPLE_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, rd_en = 0, clr_ovf = 0;
  logic [DW-1:0] in_data = '0;
  logic rd_valid, overflow;
  logic [DW-1:0] rd_data;
  logic [TW-1:0] rd_time;
  logic [$clog2(DEPTH):0] count;
  int checks = 0, errors = 0;
  int tb_ts = 0;
  logic [TW+DW-1:0] sb [$];

  chg_log #(.DW(DW), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_time(rd_time), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // reference timestamp: value of ts at the next sampling edge
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_ts <= 0;
    else tb_ts <= (tb_ts + 1) % 256;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int t);
    sb.push_back({TW'(t), DW'(d)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; rd_en = 0; clr_ovf = 0;
    sb.delete();
    step(); step();
    rst_n = 1;
  endtask

  task automatic drain();
    rd_en = 1;
    for (int i = 0; i < 20 && rd_valid; i++) step();
    rd_en = 0;
    chk("drain_empty", int'(rd_valid), 0);
    chk("drain_sb_left", sb.size(), 0);
    chk("empty_data", int'(rd_data), 0);
    chk("empty_time", int'(rd_time), 0);
  endtask

  // monitor: every accepted pop must match the oldest expected entry
  always @(negedge clk)
    if (rst_n && rd_en && rd_valid) begin
      if (sb.size() == 0) chk("pop_unexpected", 1, 0);
      else begin
        logic [TW+DW-1:0] e;
        e = sb.pop_front();
        chk("pop_data", int'(rd_data), int'(e[DW-1:0]));
        chk("pop_time", int'(rd_time), int'(e[TW+DW-1:DW]));
      end
    end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_data", int'(rd_data), 0);
    chk("rst_time", int'(rd_time), 0);
    chk("rst_ovf", int'(overflow), 0);
    // basic sequence 2,4,8,12 at ts 0..3
    in_valid = 1;
    in_data = 2;  if (F) push(2, 0); step();
    in_data = 4;  push(4, 1);  step();
    in_data = 8;  push(8, 2);  step();
    in_data = 12; push(12, 3); step();
    in_valid = 0;
    chk("seq_count", int'(count), 3 + F);
    chk("seq_valid", int'(rd_valid), 1);
    drain();
    // steady value: nothing logged
    do_reset();
    in_valid = 1; in_data = 5;
    if (F) push(5, 0);
    repeat (21) step();
    in_valid = 0;
    chk("hold_count", int'(count), F);
    chk("hold_ovf", int'(overflow), 0);
    drain();
    // overflow: 10 changes into 8 entries
    do_reset();
    in_valid = 1; in_data = 0;
    if (F) push(0, 0);
    step();
    in_valid = 0;
    if (F) drain();
    in_valid = 1;
    for (int v = 1; v <= 10; v++) begin
      in_data = DW'(v);
      if (v <= 8) push(v, tb_ts);
      step();
    end
    in_valid = 0;
    chk("full_count", int'(count), 8);
    chk("full_ovf", int'(overflow), 1);
    clr_ovf = 1; step(); clr_ovf = 0;
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_count", int'(count), 8);
    // full with simultaneous push and pop
    in_valid = 1; in_data = 11; rd_en = 1;
    push(11, tb_ts);
    step();
    in_valid = 0; rd_en = 0;
    chk("pp_count", int'(count), 8);
    chk("pp_ovf", int'(overflow), 0);
    drain();
    // timestamp wrap: change sampled at edge 257 -> ts 1
    do_reset();
    in_valid = 1; in_data = 3;
    if (F) push(3, 0);
    step();
    in_valid = 0;
    repeat (256) step();
    in_valid = 1; in_data = 9;
    push(9, 1);
    step();
    in_valid = 0;
    chk("wrap_count", int'(count), 1 + F);
    drain();
    // asynchronous reset mid-burst
    do_reset();
    in_valid = 1;
    in_data = 1; if (F) push(1, 0); step();
    in_data = 2; step();
    in_data = 3; step();
    in_data = 4; step();
    chk("burst_count", int'(count), 3 + F);
    rst_n = 0;
    #1;
    chk("ar_valid", int'(rd_valid), 0);
    chk("ar_count", int'(count), 0);
    chk("ar_data", int'(rd_data), 0);
    chk("ar_time", int'(rd_time), 0);
    chk("ar_ovf", int'(overflow), 0);
    sb.delete();
    in_valid = 0;
    rst_n = 1;
    rd_en = 1; step(); step(); rd_en = 0;
    chk("empty_pop_count", int'(count), 0);
    chk("empty_pop_valid", int'(rd_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
